// File: rtl/param_shift_dff_if.sv
// Operand/result bundle for the parametrised shift register.
// master drives the controls and data; slave is the register bank.
interface param_shift_dff_if #(
    parameter int WIDTH   = 8,
    parameter int SHAMT_W = 4
);
    logic               en;
    logic [2:0]         mode;
    logic [SHAMT_W-1:0] shamt;
    logic [WIDTH-1:0]   d;
    logic               sin;
    logic [WIDTH-1:0]   q;
    logic [WIDTH-1:0]   qn;
    logic               cout;
    logic               zero;

    modport master (
        output en, mode, shamt, d, sin,
        input  q, qn, cout, zero
    );

    modport slave (
        input  en, mode, shamt, d, sin,
        output q, qn, cout, zero
    );
endinterface

// File: rtl/param_shift_dff.sv
// WIDTH-bit register bank with clock enable, parallel load and single-cycle
// shift/rotate by a variable amount; async active-low clear, registered carry-out.
module param_shift_dff #(
    parameter int               WIDTH     = 8,
    parameter int               SHAMT_W   = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                clk,
    input  logic                clrn,
    param_shift_dff_if.slave    bus
);
    localparam logic [2:0] MODE_HOLD = 3'b000;
    localparam logic [2:0] MODE_LOAD = 3'b001;
    localparam logic [2:0] MODE_SHL  = 3'b010;
    localparam logic [2:0] MODE_SHR  = 3'b011;
    localparam logic [2:0] MODE_SAR  = 3'b100;
    localparam logic [2:0] MODE_ROTL = 3'b101;
    localparam logic [2:0] MODE_ROTR = 3'b110;
    localparam logic [2:0] MODE_SET  = 3'b111;

    logic [WIDTH-1:0] q_r;
    logic             cout_r;
    logic [WIDTH-1:0] q_nxt;
    logic             cout_nxt;

    logic [WIDTH-1:0] ones;
    logic [WIDTH-1:0] fill_l;
    logic [WIDTH-1:0] fill_r;
    logic [WIDTH:0]   ext_l;
    logic [WIDTH:0]   ext_r;
    int               k;
    int               r;

    always_comb begin
        ones     = '1;
        k        = 32'(bus.shamt);
        r        = k % WIDTH;
        fill_l   = ~(ones << k);
        fill_r   = ~(ones >> k);
        // Guard bits catch the last bit shifted out; amounts past WIDTH leave 0 there.
        ext_l    = {1'b0, q_r} << k;
        ext_r    = {q_r, 1'b0} >> k;
        q_nxt    = q_r;
        cout_nxt = cout_r;
        case (bus.mode)
            MODE_HOLD: begin
                q_nxt    = q_r;
                cout_nxt = cout_r;
            end
            MODE_LOAD: begin
                q_nxt    = bus.d;
                cout_nxt = 1'b0;
            end
            MODE_SHL: if (k != 0) begin
                q_nxt    = (q_r << k) | (bus.sin ? fill_l : '0);
                cout_nxt = ext_l[WIDTH];
            end
            MODE_SHR: if (k != 0) begin
                q_nxt    = (q_r >> k) | (bus.sin ? fill_r : '0);
                cout_nxt = ext_r[0];
            end
            MODE_SAR: if (k != 0) begin
                q_nxt    = (q_r >> k) | (q_r[WIDTH-1] ? fill_r : '0);
                cout_nxt = (k > WIDTH) ? q_r[WIDTH-1] : ext_r[0];
            end
            MODE_ROTL: if (r != 0) begin
                q_nxt    = (q_r << r) | (q_r >> (WIDTH - r));
                cout_nxt = q_nxt[0];
            end
            MODE_ROTR: if (r != 0) begin
                q_nxt    = (q_r >> r) | (q_r << (WIDTH - r));
                cout_nxt = q_nxt[WIDTH-1];
            end
            MODE_SET: begin
                q_nxt    = '1;
                cout_nxt = 1'b0;
            end
            default: begin
                q_nxt    = q_r;
                cout_nxt = cout_r;
            end
        endcase
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            q_r    <= RESET_VAL;
            cout_r <= 1'b0;
        end else if (bus.en) begin
            q_r    <= q_nxt;
            cout_r <= cout_nxt;
        end
    end

    assign bus.q    = q_r;
    assign bus.qn   = ~q_r;
    assign bus.cout = cout_r;
    assign bus.zero = (q_r == '0);
endmodule

// File: tb/tb_param_shift_dff.sv
// Directed test-plan steps followed by randomized operations, checked against
// a per-bit behavioural model of the shift/rotate rules.
module tb_param_shift_dff;
    localparam int W = 8;

    logic clk;
    logic clrn;
    int   n_cmp;
    int   n_fail;

    logic [W-1:0] mq;
    logic         mc;

    param_shift_dff_if #(.WIDTH(W), .SHAMT_W(4)) bus ();

    param_shift_dff #(.WIDTH(W), .SHAMT_W(4), .RESET_VAL(8'h00)) dut (
        .clk  (clk),
        .clrn (clrn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".q"},    bus.q,             mq);
        chk({tag, ".qn"},   bus.qn,            ~mq);
        chk({tag, ".cout"}, {7'b0, bus.cout},  {7'b0, mc});
        chk({tag, ".zero"}, {7'b0, bus.zero},  {7'b0, (mq == 8'h00)});
    endtask

    function automatic void model(input logic [W-1:0] q, input logic c, input logic [2:0] m,
                                  input int k, input logic [W-1:0] dd, input logic s,
                                  output logic [W-1:0] nq, output logic nc);
        int r;
        nq = q;
        nc = c;
        r  = k % W;
        case (m)
            3'd1: begin nq = dd; nc = 1'b0; end
            3'd2: if (k != 0) begin
                for (int i = 0; i < W; i++) nq[i] = (i - k >= 0) ? q[i-k] : s;
                nc = (k <= W) ? q[W-k] : 1'b0;
            end
            3'd3: if (k != 0) begin
                for (int i = 0; i < W; i++) nq[i] = (i + k < W) ? q[i+k] : s;
                nc = (k <= W) ? q[k-1] : 1'b0;
            end
            3'd4: if (k != 0) begin
                for (int i = 0; i < W; i++) nq[i] = (i + k < W) ? q[i+k] : q[W-1];
                nc = (k <= W) ? q[k-1] : q[W-1];
            end
            3'd5: if (r != 0) begin
                for (int i = 0; i < W; i++) nq[i] = q[(i - r + W) % W];
                nc = nq[0];
            end
            3'd6: if (r != 0) begin
                for (int i = 0; i < W; i++) nq[i] = q[(i + r) % W];
                nc = nq[W-1];
            end
            3'd7: begin nq = '1; nc = 1'b0; end
            default: begin nq = q; nc = c; end
        endcase
    endfunction

    // Inputs are driven 1 time unit after a rising edge; results sampled 1 unit after the next.
    task automatic step(input string tag, input logic e, input logic [2:0] m,
                        input logic [3:0] k, input logic [W-1:0] dd, input logic s);
        logic [W-1:0] nq;
        logic         nc;
        bus.en    = e;
        bus.mode  = m;
        bus.shamt = k;
        bus.d     = dd;
        bus.sin   = s;
        model(mq, mc, m, int'(k), dd, s, nq, nc);
        @(posedge clk);
        #1;
        if (e) begin
            mq = nq;
            mc = nc;
        end
        chk_all(tag);
    endtask

    task automatic clear_pulse(input string tag);
        clrn = 1'b0;
        #1;
        mq = 8'h00;
        mc = 1'b0;
        chk_all(tag);
        #1;
        clrn = 1'b1;
    endtask

    initial begin
        n_cmp     = 0;
        n_fail    = 0;
        clrn      = 1'b0;
        bus.en    = 1'b0;
        bus.mode  = 3'd0;
        bus.shamt = 4'd0;
        bus.d     = 8'h00;
        bus.sin   = 1'b0;
        mq        = 8'h00;
        mc        = 1'b0;

        @(posedge clk);
        #1;
        chk_all("reset");
        clrn = 1'b1;

        step("load_5a", 1'b1, 3'd1, 4'd0, 8'h5A, 1'b0);
        chk("tp_load_5a", bus.q, 8'h5A);
        clear_pulse("async_clr");
        chk("tp_clr_qn", bus.qn, 8'hFF);

        step("load_a5", 1'b1, 3'd1, 4'd0, 8'hA5, 1'b0);
        chk("tp_load_a5", bus.q, 8'hA5);
        step("shl3", 1'b1, 3'd2, 4'd3, 8'h00, 1'b1);
        chk("tp_shl3", bus.q, 8'h2F);
        chk("tp_shl3_c", {7'b0, bus.cout}, 8'h01);
        step("shr10", 1'b1, 3'd3, 4'd10, 8'h00, 1'b0);
        chk("tp_shr10", bus.q, 8'h00);
        chk("tp_shr10_z", {7'b0, bus.zero}, 8'h01);

        step("load_96", 1'b1, 3'd1, 4'd0, 8'h96, 1'b0);
        step("sar2", 1'b1, 3'd4, 4'd2, 8'h00, 1'b0);
        chk("tp_sar2", bus.q, 8'hE5);
        step("sar12", 1'b1, 3'd4, 4'd12, 8'h00, 1'b0);
        chk("tp_sar12", bus.q, 8'hFF);
        chk("tp_sar12_c", {7'b0, bus.cout}, 8'h01);

        step("load_81", 1'b1, 3'd1, 4'd0, 8'h81, 1'b0);
        step("rotr9", 1'b1, 3'd6, 4'd9, 8'h00, 1'b0);
        chk("tp_rotr9", bus.q, 8'hC0);
        step("rotl8", 1'b1, 3'd5, 4'd8, 8'h00, 1'b0);
        chk("tp_rotl8", bus.q, 8'hC0);
        chk("tp_rotl8_c", {7'b0, bus.cout}, 8'h01);
        step("shl0", 1'b1, 3'd2, 4'd0, 8'h00, 1'b1);
        step("shl8", 1'b1, 3'd2, 4'd8, 8'h00, 1'b0);

        step("load_3c", 1'b1, 3'd1, 4'd0, 8'h3C, 1'b0);
        for (int i = 0; i < 3; i++) step("en0_hold", 1'b0, 3'd1, 4'd0, 8'h00, 1'b0);
        chk("tp_en0", bus.q, 8'h3C);
        step("set", 1'b1, 3'd7, 4'd0, 8'h00, 1'b0);
        chk("tp_set_qn", bus.qn, 8'h00);

        // Clear held across an enabled LOAD edge, then the LOAD lands after release.
        bus.en = 1'b1; bus.mode = 3'd1; bus.d = 8'h77; bus.shamt = 4'd0; bus.sin = 1'b0;
        clrn = 1'b0;
        @(posedge clk);
        #1;
        mq = 8'h00;
        mc = 1'b0;
        chk_all("clr_across_edge");
        clrn = 1'b1;
        step("load_after_clr", 1'b1, 3'd1, 4'd0, 8'h77, 1'b0);
        chk("tp_load_77", bus.q, 8'h77);

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 24) == 0) clear_pulse("rnd_clr");
            step("rnd",
                 ($urandom_range(0, 7) != 0),
                 3'($urandom_range(0, 7)),
                 4'($urandom_range(0, 15)),
                 8'($urandom),
                 1'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/param_shift_dff.md
Name: param_shift_dff

Overview:
- Parametrised successor to the single-bit D flip-flop: a WIDTH-bit register bank with asynchronous active-low clear.
- Adds clock enable, parallel load, and multi-bit shift/rotate modes with a registered carry-out.
- Used as the general-purpose storage/shift element in datapaths: serialisers, barrel-shift stages, LFSR seeds.
- Keeps the complementary q/qn output pair.

Parameters:
- WIDTH, 8, register width in bits (>=2).
- SHAMT_W, 4, width of the shift-amount input; amounts up to 2^SHAMT_W-1, may exceed WIDTH.
- RESET_VAL, {WIDTH{1'b0}}, value loaded into q on asynchronous clear.

Ports:
- clk  input  1  rising-edge clock.
- clrn  input  1  asynchronous active-low clear; forces q=RESET_VAL.
- en  input  1  clock enable; 0 = hold everything.
- mode  input  3  operation select (see Behaviour).
- shamt  input  SHAMT_W  shift/rotate amount k.
- d  input  WIDTH  parallel load data.
- sin  input  1  serial fill bit for logical shifts.
- q  output  WIDTH  register contents.
- qn  output  WIDTH  bitwise complement of q, always ~q.
- cout  output  1  registered last bit shifted or rotated out.
- zero  output  1  combinational, 1 when q==0.

Behaviour:
- Reset and clock discipline:
  - Clock is clk; reset is asynchronous and active-low on clrn.
  - While clrn=0: q=RESET_VAL, qn=~RESET_VAL, cout=0, regardless of clk. Effect is immediate, not edge-aligned.
  - Release of clrn is sampled normally; the first rising edge with clrn=1 applies the selected operation.
  - Clear mid-operation discards any pending operation; no state survives.
- Update timing:
  - All state updates occur on the rising clk edge when clrn=1 and en=1.
  - Latency is one cycle: the new q is visible after the edge.
  - en=0 holds q and cout for any mode.
- mode encoding, with k=shamt:
  - 000 HOLD: q and cout unchanged.
  - 001 LOAD: q<=d, cout<=0.
  - 010 SHL: q<=(q<<k), vacated low k bits all = sin.
  - 011 SHR: q<=(q>>k), vacated high k bits all = sin.
  - 100 SAR: arithmetic right shift, vacated bits = old q[WIDTH-1].
  - 101 ROTL: rotate left by k mod WIDTH.
  - 110 ROTR: rotate right by k mod WIDTH.
  - 111 SET: q<=all ones, cout<=0.
- k=0: shift and rotate modes behave as HOLD; cout unchanged.
- k>=WIDTH:
  - SHL/SHR: q = all sin.
  - SAR: q = all old msb.
  - Rotates: use k mod WIDTH; k mod WIDTH = 0 behaves as HOLD (cout unchanged).
- cout on shifts, 1<=k<=WIDTH:
  - SHL = old q[WIDTH-k].
  - SHR/SAR = old q[k-1].
- cout on shifts, k>WIDTH:
  - SHL/SHR = 0.
  - SAR = old q[WIDTH-1].
- cout on rotates with effective k!=0:
  - ROTL = new q[0].
  - ROTR = new q[WIDTH-1].
- qn is derived from q; q and qn are never equal in any bit, including during reset.
- zero is purely combinational from q; no extra latency.
- Implementation constraints:
  - The shifter is combinational ahead of the register; no multi-cycle shifting.
  - d, mode, shamt and sin are sampled only at the enabled edge.

Test Plan:
- Assert clrn=0 between edges with q=0x5A -> q=0x00, qn=0xFF, cout=0 immediately. Release, LOAD d=0xA5 en=1 -> q=0xA5 after one edge, zero=0.
- q=0xA5, SHL k=3 sin=1 -> q=0x2F, cout=1. Then SHR k=10 sin=0 -> q=0x00, cout=0, zero=1.
- LOAD 0x96, then SAR k=2 -> q=0xE5, cout=1. Then SAR k=12 -> q=0xFF, cout=1.
- LOAD 0x81, then ROTR k=9 -> q=0xC0, cout=1. Then ROTL k=8 -> q=0xC0, cout unchanged.
- q=0x3C, en=0 with mode=LOAD d=0x00 for 3 edges -> q stays 0x3C. SET with en=1 -> q=0xFF, qn=0x00, cout=0.
- Pull clrn low during an enabled LOAD d=0x77 across a clock edge -> q=0x00 held. First edge after release -> q=0x77.
